// File: rtl/sn_to_bn.sv
// Stochastic-to-binary converter: counts the ones in a fixed-length serial
// bitstream and emits a truncated, saturated binary value with a valid strobe.
module sn_to_bn #(
  parameter int BN_W     = 4,
  parameter int LEN_LOG2 = 4
) (
  input  logic                i_clk_stb,
  input  logic                i_rst_n_stb,
  input  logic                i_start_stb,
  input  logic                i_stop_stb,
  input  logic                i_sn_bit,
  input  logic                i_sn_valid,
  output logic [BN_W-1:0]     o_x_bn,
  output logic [LEN_LOG2:0]   o_ones_stb,
  output logic                o_valid_stb,
  output logic                o_busy_stb
);

  generate
    if (LEN_LOG2 < BN_W) begin : g_bad_params
      $error("sn_to_bn: LEN_LOG2 must be >= BN_W");
    end
  endgenerate

  localparam int SHIFT = (LEN_LOG2 >= BN_W) ? (LEN_LOG2 - BN_W) : 0;
  localparam logic [BN_W-1:0]   X_MAX  = '1;
  localparam logic [LEN_LOG2:0] X_MAX_W = (LEN_LOG2+1)'((1 << BN_W) - 1);

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  state_t                state_reg, state_next;
  logic [LEN_LOG2-1:0]   len_cnt_reg, len_cnt_next;
  logic [LEN_LOG2:0]     ones_cnt_reg, ones_cnt_next;
  logic [BN_W-1:0]       x_bn_reg, x_bn_next;
  logic [LEN_LOG2:0]     ones_out_reg, ones_out_next;
  logic [LEN_LOG2:0]     ones_final;
  logic [LEN_LOG2:0]     ones_scaled;
  logic [BN_W-1:0]       x_final;
  logic                  last_bit;

  // The completing bit is folded in combinationally so the result latches on its edge.
  assign ones_final  = ones_cnt_reg + {{LEN_LOG2{1'b0}}, i_sn_bit};
  assign ones_scaled = ones_final >> SHIFT;
  assign x_final     = (ones_scaled > X_MAX_W) ? X_MAX : ones_scaled[BN_W-1:0];
  assign last_bit    = &len_cnt_reg;

  always_ff @(posedge i_clk_stb or negedge i_rst_n_stb) begin
    if (!i_rst_n_stb) begin
      state_reg    <= IDLE;
      len_cnt_reg  <= '0;
      ones_cnt_reg <= '0;
      x_bn_reg     <= '0;
      ones_out_reg <= '0;
    end else begin
      state_reg    <= state_next;
      len_cnt_reg  <= len_cnt_next;
      ones_cnt_reg <= ones_cnt_next;
      x_bn_reg     <= x_bn_next;
      ones_out_reg <= ones_out_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    len_cnt_next  = '0;
    ones_cnt_next = '0;
    x_bn_next     = x_bn_reg;
    ones_out_next = ones_out_reg;
    case (state_reg)
      IDLE: begin
        if (i_start_stb && !i_stop_stb) state_next = ACC;
      end
      ACC: begin
        // Stop beats start, and both beat the completing bit.
        if (i_stop_stb) begin
          state_next = IDLE;
        end else if (i_start_stb) begin
          state_next = ACC;
        end else if (i_sn_valid && last_bit) begin
          state_next    = DONE;
          x_bn_next     = x_final;
          ones_out_next = ones_final;
        end else if (i_sn_valid) begin
          len_cnt_next  = len_cnt_reg + LEN_LOG2'(1);
          ones_cnt_next = ones_final;
        end else begin
          len_cnt_next  = len_cnt_reg;
          ones_cnt_next = ones_cnt_reg;
        end
      end
      DONE: begin
        state_next = (i_start_stb && !i_stop_stb) ? ACC : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign o_x_bn      = x_bn_reg;
  assign o_ones_stb  = ones_out_reg;
  assign o_valid_stb = (state_reg == DONE);
  assign o_busy_stb  = (state_reg == ACC);

endmodule

// File: tb/tb_sn_to_bn.sv
// Bench for sn_to_bn: random streams with random stalls against a counting
// reference model, plus the abort/restart/back-to-back corner cases.
module tb_sn_to_bn;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, stop, sn_bit, sn_valid;
  logic [3:0] x1, x2;
  logic [4:0] ones1;
  logic [6:0] ones2;
  logic       valid1, busy1, valid2, busy2;

  int n_tests = 0;
  int n_fail  = 0;
  int vcount1 = 0;

  always #5 clk = ~clk;

  sn_to_bn #(.BN_W(4), .LEN_LOG2(4)) dut (
    .i_clk_stb(clk), .i_rst_n_stb(rst_n), .i_start_stb(start), .i_stop_stb(stop),
    .i_sn_bit(sn_bit), .i_sn_valid(sn_valid), .o_x_bn(x1), .o_ones_stb(ones1),
    .o_valid_stb(valid1), .o_busy_stb(busy1)
  );

  sn_to_bn #(.BN_W(4), .LEN_LOG2(6)) dut64 (
    .i_clk_stb(clk), .i_rst_n_stb(rst_n), .i_start_stb(start), .i_stop_stb(stop),
    .i_sn_bit(sn_bit), .i_sn_valid(sn_valid), .o_x_bn(x2), .o_ones_stb(ones2),
    .o_valid_stb(valid2), .o_busy_stb(busy2)
  );

  always @(negedge clk) if (valid1 === 1'b1) vcount1++;

  // Reference scaling: truncating shift, then clamp to the output range.
  function automatic int ref_x(input int ones, input int len_log2, input int bn_w);
    int v;
    v = ones >> (len_log2 - bn_w);
    if (v > (1 << bn_w) - 1) v = (1 << bn_w) - 1;
    return v;
  endfunction

  function automatic logic [63:0] gen_bits(input int len, input int k);
    logic [63:0] b;
    b = '0;
    while ($countones(b) < k) b[$urandom_range(0, len-1)] = 1'b1;
    return b;
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Drives an optional start pulse, then len valid bits with 'stalls' stall
  // cycles scattered before them. Returns right after the last bit's edge.
  task automatic send_bits(input logic [63:0] bits, input int len, input int stalls,
                           input bit with_start);
    int stall_before[64];
    for (int i = 0; i < 64; i++) stall_before[i] = 0;
    for (int s = 0; s < stalls; s++) stall_before[$urandom_range(0, len-1)]++;
    if (with_start) begin
      start = 1'b1;
      step();
      start = 1'b0;
    end
    for (int i = 0; i < len; i++) begin
      for (int s = 0; s < stall_before[i]; s++) begin
        sn_valid = 1'b0;
        sn_bit   = 1'b1;
        step();
      end
      sn_valid = 1'b1;
      sn_bit   = bits[i];
      step();
    end
    sn_valid = 1'b0;
    sn_bit   = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 0; stop = 0; sn_bit = 0; sn_valid = 0;
    step(); step();
    rst_n = 1'b1;
    step();
    n_tests++;
    if ({x1, ones1, valid1, busy1} !== 11'd0) begin
      n_fail++;
      $display("FAIL reset: x=%0d ones=%0d valid=%b busy=%b, required all 0", x1, ones1, valid1, busy1);
    end
    $display("[TB] reset checked");
  endtask

  task automatic check_result(input string name, input int exp_ones, input int v0);
    int exp_x;
    exp_x = ref_x(exp_ones, 4, 4);
    n_tests++;
    if (valid1 !== 1'b1 || ones1 !== exp_ones[4:0] || x1 !== exp_x[3:0]) begin
      n_fail++;
      $display("FAIL %s: valid=%b ones=%0d x=%0d, required valid=1 ones=%0d x=%0d",
               name, valid1, ones1, x1, exp_ones, exp_x);
    end
    step();
    n_tests++;
    if (valid1 !== 1'b0 || busy1 !== 1'b0 || vcount1 - v0 !== 1) begin
      n_fail++;
      $display("FAIL %s_pulse: valid=%b busy=%b pulses=%0d, required 0 0 1",
               name, valid1, busy1, vcount1 - v0);
    end
    $display("[TB] %s: ones=%0d x=%0d expected %0d", name, ones1, x1, exp_ones);
  endtask

  task automatic test_count10;
    logic [63:0] b;
    int v0;
    b = gen_bits(16, 10);
    v0 = vcount1;
    send_bits(b, 16, 0, 1);
    check_result("count10", 10, v0);
  endtask

  task automatic test_stalls;
    logic [63:0] b;
    int v0;
    b = gen_bits(16, 3);
    v0 = vcount1;
    send_bits(b, 16, 5, 1);
    check_result("stalls", 3, v0);
  endtask

  task automatic test_saturation;
    int v0;
    v0 = vcount1;
    send_bits(64'hFFFF, 16, 2, 1);
    check_result("all_ones", 16, v0);
    v0 = vcount1;
    send_bits(64'h0, 16, 2, 1);
    check_result("all_zeros", 0, v0);
  endtask

  task automatic test_random;
    logic [63:0] b;
    int v0;
    for (int it = 0; it < 8; it++) begin
      b = gen_bits(16, $urandom_range(0, 16));
      v0 = vcount1;
      send_bits(b, 16, $urandom_range(0, 4), 1);
      check_result("random", $countones(b[15:0]), v0);
    end
  endtask

  task automatic test_abort;
    int v0;
    v0 = vcount1;
    send_bits(gen_bits(16, 9), 16, 0, 1);
    check_result("abort_prev", 9, v0);
    send_bits(gen_bits(16, 5), 8, 1, 1);
    n_tests++;
    if (busy1 !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_busy: busy=%b, required 1", busy1);
    end
    v0 = vcount1;
    stop = 1'b1;
    step();
    stop = 1'b0;
    for (int i = 0; i < 16; i++) begin
      sn_valid = 1'b1; sn_bit = 1'b1;
      step();
    end
    sn_valid = 1'b0;
    step();
    n_tests++;
    if (busy1 !== 1'b0 || ones1 !== 5'd9 || x1 !== 4'd9 || vcount1 !== v0) begin
      n_fail++;
      $display("FAIL abort_stop: busy=%b ones=%0d x=%0d pulses=%0d, required 0 9 9 0",
               busy1, ones1, x1, vcount1 - v0);
    end
    $display("[TB] abort_stop: ones=%0d x=%0d held", ones1, x1);
    v0 = vcount1;
    send_bits(gen_bits(16, 8), 8, 0, 1);
    send_bits(gen_bits(16, 4), 16, 1, 1);
    check_result("abort_restart", 4, v0);
  endtask

  task automatic test_coincident;
    int v0;
    v0 = vcount1;
    send_bits(64'hFFFF, 15, 0, 1);
    stop = 1'b1; sn_valid = 1'b1; sn_bit = 1'b1;
    step();
    stop = 1'b0; sn_valid = 1'b0;
    step();
    n_tests++;
    if (busy1 !== 1'b0 || ones1 !== 5'd4 || vcount1 !== v0) begin
      n_fail++;
      $display("FAIL stop_on_last: busy=%b ones=%0d pulses=%0d, required 0 4 0",
               busy1, ones1, vcount1 - v0);
    end
    send_bits(64'hFFFF, 15, 0, 1);
    start = 1'b1; sn_valid = 1'b1; sn_bit = 1'b1;
    step();
    start = 1'b0; sn_valid = 1'b0;
    n_tests++;
    if (busy1 !== 1'b1 || valid1 !== 1'b0 || vcount1 !== v0) begin
      n_fail++;
      $display("FAIL start_on_last: busy=%b valid=%b pulses=%0d, required 1 0 0",
               busy1, valid1, vcount1 - v0);
    end
    send_bits(gen_bits(16, 6), 16, 2, 0);
    check_result("start_on_last", 6, v0);
  endtask

  task automatic test_back_to_back;
    int v0;
    v0 = vcount1;
    send_bits(gen_bits(16, 7), 16, 0, 1);
    n_tests++;
    if (valid1 !== 1'b1 || ones1 !== 5'd7 || x1 !== 4'd7) begin
      n_fail++;
      $display("FAIL b2b_first: valid=%b ones=%0d x=%0d, required 1 7 7", valid1, ones1, x1);
    end
    start = 1'b1;
    step();
    start = 1'b0;
    n_tests++;
    if (busy1 !== 1'b1 || valid1 !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_gap: busy=%b valid=%b, required 1 0", busy1, valid1);
    end
    send_bits(gen_bits(16, 12), 16, 0, 0);
    check_result("b2b_second", 12, v0 + 1);
  endtask

  task automatic test_len64;
    logic [63:0] b;
    int k, ex;
    for (int it = 0; it < 2; it++) begin
      k = (it == 0) ? 40 : $urandom_range(0, 64);
      b = gen_bits(64, k);
      send_bits(b, 64, it * 3, 1);
      ex = ref_x(k, 6, 4);
      n_tests++;
      if (valid2 !== 1'b1 || ones2 !== k[6:0] || x2 !== ex[3:0]) begin
        n_fail++;
        $display("FAIL len64: valid=%b ones=%0d x=%0d, required 1 %0d %0d", valid2, ones2, x2, k, ex);
      end
      $display("[TB] len64: ones=%0d x=%0d expected %0d/%0d", ones2, x2, k, ex);
      step();
    end
  endtask

  task automatic test_reset_mid;
    int v0;
    v0 = vcount1;
    send_bits(gen_bits(16, 5), 16, 0, 1);
    check_result("pre_reset", 5, v0);
    send_bits(gen_bits(16, 8), 6, 0, 1);
    #3 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({x1, ones1, valid1, busy1} !== 11'd0) begin
      n_fail++;
      $display("FAIL reset_mid: x=%0d ones=%0d valid=%b busy=%b, required all 0", x1, ones1, valid1, busy1);
    end
    step();
    rst_n = 1'b1;
    sn_valid = 1'b1; sn_bit = 1'b1;
    step(); step();
    sn_valid = 1'b0;
    n_tests++;
    if (busy1 !== 1'b0 || ones1 !== 5'd0) begin
      n_fail++;
      $display("FAIL reset_release: busy=%b ones=%0d, required 0 0", busy1, ones1);
    end
    $display("[TB] reset_mid checked");
  endtask

  initial begin
    test_reset();
    test_count10();
    test_stalls();
    test_saturation();
    test_random();
    test_abort();
    test_coincident();
    test_back_to_back();
    test_len64();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
